// File: rtl/washer_actuator_driver_if.sv
// Bundle of controller commands and gated actuator outputs for the washer
// actuator driver.
//   master : controller/plant side; drives commands, observes actuator pins
//   slave  : driver side; consumes commands, drives actuator pins and fault
// Commands : zheng, fan, inlet, drain, dry, emergency, fault_clr
// Outputs  : mot_fwd, mot_rev, inlet_o, drain_o, dry_o, fault, fault_code[1:0]
interface washer_actuator_driver_if;
  logic       zheng;
  logic       fan;
  logic       inlet;
  logic       drain;
  logic       dry;
  logic       emergency;
  logic       fault_clr;
  logic       mot_fwd;
  logic       mot_rev;
  logic       inlet_o;
  logic       drain_o;
  logic       dry_o;
  logic       fault;
  logic [1:0] fault_code;

  modport master (
    output zheng, fan, inlet, drain, dry, emergency, fault_clr,
    input  mot_fwd, mot_rev, inlet_o, drain_o, dry_o, fault, fault_code
  );

  modport slave (
    input  zheng, fan, inlet, drain, dry, emergency, fault_clr,
    output mot_fwd, mot_rev, inlet_o, drain_o, dry_o, fault, fault_code
  );
endinterface

// File: rtl/washer_actuator_driver.sv
// Safe output stage between the washer controller and its actuators.
// Enforces motor dead time on any stop/reversal, the inlet/drain interlock,
// an inlet-overflow watchdog and a latched, prioritised fault.
//   clk        : rising-edge clock
//   rst        : asynchronous active-low reset
//   bus.slave  : commands in (zheng, fan, inlet, drain, dry, emergency,
//                fault_clr); registered outputs (mot_fwd, mot_rev, inlet_o,
//                drain_o, dry_o, fault, fault_code: 00 none, 01 direction
//                conflict, 10 inlet timeout, 11 emergency)
module washer_actuator_driver #(
  parameter int unsigned DEAD_CYC  = 8,
  parameter int unsigned INLET_MAX = 600,
  parameter int unsigned CNT_W     = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  washer_actuator_driver_if.slave   bus
);

  typedef enum logic [1:0] {M_IDLE, M_FWD, M_REV, M_DEAD} mstate_e;

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEAD_CYC - 1);
  localparam logic [CNT_W-1:0] WDG_LAST  = CNT_W'(INLET_MAX - 1);

  mstate_e          state_q, state_d;
  logic [CNT_W-1:0] dcnt_q, dcnt_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic             fault_q, fault_d;
  logic [1:0]       code_q, code_d;
  logic             mot_fwd_q, mot_fwd_d;
  logic             mot_rev_q, mot_rev_d;
  logic             inlet_o_q, inlet_o_d;
  logic             drain_o_q, drain_o_d;
  logic             dry_o_q, dry_o_d;

  logic       both_dir;
  logic       clear_ok;
  logic [1:0] new_code;

  always_comb begin
    both_dir = bus.zheng && bus.fan;
    clear_ok = bus.fault_clr && !bus.emergency && !both_dir;

    // Codes are numerically ordered by priority, so the highest source wins
    // and a latched code is only replaced by a larger one.
    new_code = 2'b00;
    if (bus.emergency)
      new_code = 2'b11;
    else if (inlet_o_q && (wcnt_q == WDG_LAST))
      new_code = 2'b10;
    else if ((state_q == M_IDLE) && both_dir)
      new_code = 2'b01;

    fault_d = fault_q;
    code_d  = code_q;
    if (fault_q && clear_ok) begin
      fault_d = 1'b0;
      code_d  = '0;
    end else if (new_code != 2'b00) begin
      fault_d = 1'b1;
      if (new_code > code_q)
        code_d = new_code;
    end

    state_d = state_q;
    dcnt_d  = dcnt_q;
    unique case (state_q)
      M_IDLE: begin
        if (!fault_d) begin
          if (bus.zheng && !bus.fan)
            state_d = M_FWD;
          else if (bus.fan && !bus.zheng)
            state_d = M_REV;
        end
      end
      M_FWD: begin
        if (fault_d || !(bus.zheng && !bus.fan)) begin
          state_d = M_DEAD;
          dcnt_d  = DEAD_LOAD;
        end
      end
      M_REV: begin
        if (fault_d || !(bus.fan && !bus.zheng)) begin
          state_d = M_DEAD;
          dcnt_d  = DEAD_LOAD;
        end
      end
      M_DEAD: begin
        if (dcnt_q == '0)
          state_d = M_IDLE;
        else
          dcnt_d = dcnt_q - CNT_ONE;
      end
      default: state_d = M_IDLE;
    endcase

    mot_fwd_d = (state_d == M_FWD);
    mot_rev_d = (state_d == M_REV);
    inlet_o_d = bus.inlet && !bus.drain && !fault_d;
    drain_o_d = bus.drain && !fault_d;
    dry_o_d   = bus.dry && !bus.inlet && !fault_d;

    // Counts edges the inlet has stayed open; restarts whenever it closes.
    wcnt_d = (inlet_o_d && inlet_o_q) ? (wcnt_q + CNT_ONE) : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= M_IDLE;
      dcnt_q    <= '0;
      wcnt_q    <= '0;
      fault_q   <= 1'b0;
      code_q    <= '0;
      mot_fwd_q <= 1'b0;
      mot_rev_q <= 1'b0;
      inlet_o_q <= 1'b0;
      drain_o_q <= 1'b0;
      dry_o_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      dcnt_q    <= dcnt_d;
      wcnt_q    <= wcnt_d;
      fault_q   <= fault_d;
      code_q    <= code_d;
      mot_fwd_q <= mot_fwd_d;
      mot_rev_q <= mot_rev_d;
      inlet_o_q <= inlet_o_d;
      drain_o_q <= drain_o_d;
      dry_o_q   <= dry_o_d;
    end
  end

  assign bus.mot_fwd    = mot_fwd_q;
  assign bus.mot_rev    = mot_rev_q;
  assign bus.inlet_o    = inlet_o_q;
  assign bus.drain_o    = drain_o_q;
  assign bus.dry_o      = dry_o_q;
  assign bus.fault      = fault_q;
  assign bus.fault_code = code_q;

endmodule
